// File: rtl/gpio_mux_regfile.sv
// GPIO register file: per-pin direction, open-drain, source select and rising-edge
// interrupt status, with a single-cycle registered read path and bus passthrough.
module gpio_mux_regfile #(
  parameter int unsigned AddrWidth    = 16,
  parameter int unsigned BusWidth     = 32,
  parameter int unsigned NumGPIO      = 4,
  parameter int unsigned GPIOWidth    = 36,
  parameter int unsigned PinsPerWord  = 24,
  parameter int unsigned PortNumWidth = 8,
  parameter int unsigned BaseAddr     = 'h1000,
  localparam int unsigned P = NumGPIO * GPIOWidth
) (
  input  logic                      reg_clk,
  input  logic                      reset_reg_N,
  input  logic                      write_reg,
  input  logic                      read_reg,
  input  logic [AddrWidth-1:0]      busaddress,
  input  logic [BusWidth-1:0]       busdata_in,
  input  logic [BusWidth-1:0]       busdata_fromhm2,
  input  logic [P-1:0]              pin_in,
  output logic [BusWidth-1:0]       busdata_out,
  output logic                      read_valid,
  output logic [P-1:0]              oe,
  output logic [P-1:0]              od,
  output logic [P*PortNumWidth-1:0] portsel,
  output logic                      irq
);

  localparam int unsigned NW   = (P + PinsPerWord - 1) / PinsPerWord;
  localparam int unsigned NM   = (P + 3) / 4;
  localparam int unsigned WinW = AddrWidth - 8;

  localparam logic [WinW-1:0] WinDdr  = WinW'(1);
  localparam logic [WinW-1:0] WinInp  = WinW'(2);
  localparam logic [WinW-1:0] WinOdr  = WinW'(3);
  localparam logic [WinW-1:0] WinMux  = WinW'(4);
  localparam logic [WinW-1:0] WinEen  = WinW'(5);
  localparam logic [WinW-1:0] WinEst  = WinW'(6);

  // Top two pins of every connector are locked: always driven, push-pull, identity select.
  function automatic logic [P-1:0] rsv_mask();
    logic [P-1:0] m;
    m = '0;
    for (int i = 0; i < P; i++) m[i] = (i % GPIOWidth) >= (GPIOWidth - 2);
    return m;
  endfunction

  localparam logic [P-1:0] RsvMask = rsv_mask();

  logic [AddrWidth-1:0] off;
  logic [WinW-1:0]      win;
  logic [7:0]           k;
  logic                 in_word;
  logic                 is_ddr, is_inp, is_odr, is_mux, is_een, is_est, valid;
  logic [BusWidth-1:0]  rdata;
  logic [P-1:0]         edge_en, edge_stat, stat_clr, stat_next;
  logic [P-1:0]         s1, s2, s3;

  // Address decode
  always_comb begin
    off     = busaddress - AddrWidth'(BaseAddr);
    win     = off[AddrWidth-1:8];
    k       = off[7:0] >> 2;
    in_word = 32'(k) < NW;
    is_ddr  = (win == WinDdr) && in_word;
    is_inp  = (win == WinInp) && in_word;
    is_odr  = (win == WinOdr) && in_word;
    is_een  = (win == WinEen) && in_word;
    is_est  = (win == WinEst) && in_word;
    is_mux  = (win == WinMux) && (32'(k) < NM);
    valid   = is_ddr | is_inp | is_odr | is_mux | is_een | is_est;
  end

  // Read data gather and write-1-to-clear mask; a same-cycle edge overrides the clear
  always_comb begin
    rdata    = '0;
    stat_clr = '0;
    for (int i = 0; i < P; i++) begin
      if (32'(k) == i / PinsPerWord) begin
        if (is_ddr) rdata[i % PinsPerWord] = oe[i];
        if (is_inp) rdata[i % PinsPerWord] = s2[i];
        if (is_odr) rdata[i % PinsPerWord] = od[i];
        if (is_een) rdata[i % PinsPerWord] = edge_en[i];
        if (is_est) rdata[i % PinsPerWord] = edge_stat[i];
        if (write_reg && is_est) stat_clr[i] = busdata_in[i % PinsPerWord];
      end
      if (is_mux && (32'(k) == i / 4))
        rdata[(i % 4) * 8 +: PortNumWidth] = portsel[i * PortNumWidth +: PortNumWidth];
    end
    stat_next = (edge_stat & ~stat_clr) | (s2 & ~s3 & edge_en);
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      oe          <= RsvMask;
      od          <= '0;
      edge_en     <= '0;
      edge_stat   <= '0;
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      irq         <= 1'b0;
      busdata_out <= '0;
      read_valid  <= 1'b0;
      for (int i = 0; i < P; i++) portsel[i * PortNumWidth +: PortNumWidth] <= PortNumWidth'(i);
    end else begin
      s1        <= pin_in;
      s2        <= s1;
      s3        <= s2;
      edge_stat <= stat_next;
      irq       <= |(edge_stat & edge_en);
      for (int i = 0; i < P; i++) begin
        if (write_reg && (32'(k) == i / PinsPerWord)) begin
          if (is_ddr && !RsvMask[i]) oe[i] <= busdata_in[i % PinsPerWord];
          if (is_odr && !RsvMask[i]) od[i] <= busdata_in[i % PinsPerWord];
          if (is_een) edge_en[i] <= busdata_in[i % PinsPerWord];
        end
        if (write_reg && is_mux && (32'(k) == i / 4) && !RsvMask[i])
          portsel[i * PortNumWidth +: PortNumWidth] <= busdata_in[(i % 4) * 8 +: PortNumWidth];
      end
      // Reads see pre-write register contents; other cycles forward the upstream bus
      if (read_reg && valid) begin
        busdata_out <= rdata;
        read_valid  <= 1'b1;
      end else begin
        busdata_out <= busdata_fromhm2;
        read_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_mux_regfile.sv
// Directed bench for gpio_mux_regfile: read responses go through an expected-value
// queue; register side effects are checked directly on oe/od/portsel/irq.
module tb_gpio_mux_regfile;

  localparam int unsigned P   = 144;
  localparam int unsigned PNW = 8;

  logic             reg_clk = 1'b0;
  logic             reset_reg_N;
  logic             write_reg;
  logic             read_reg;
  logic [15:0]      busaddress;
  logic [31:0]      busdata_in;
  logic [31:0]      busdata_fromhm2;
  logic [P-1:0]     pin_in;
  logic [31:0]      busdata_out;
  logic             read_valid;
  logic [P-1:0]     oe;
  logic [P-1:0]     od;
  logic [P*PNW-1:0] portsel;
  logic             irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  gpio_mux_regfile dut (
    .reg_clk         (reg_clk),
    .reset_reg_N     (reset_reg_N),
    .write_reg       (write_reg),
    .read_reg        (read_reg),
    .busaddress      (busaddress),
    .busdata_in      (busdata_in),
    .busdata_fromhm2 (busdata_fromhm2),
    .pin_in          (pin_in),
    .busdata_out     (busdata_out),
    .read_valid      (read_valid),
    .oe              (oe),
    .od              (od),
    .portsel         (portsel),
    .irq             (irq)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: read_valid must match whether a response is owed; pop and compare it
  task automatic monitor();
    logic [31:0] e;
    check("read_valid", 256'(read_valid), 256'(exp_q.size() != 0));
    if (read_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("read_data", 256'(busdata_out), 256'(e));
    end
  endtask

  task automatic step();
    @(posedge reg_clk);
    #1;
    monitor();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    write_reg  = 1'b1;
    busaddress = a;
    busdata_in = d;
    step();
    write_reg  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    read_reg   = 1'b1;
    busaddress = a;
    exp_q.push_back(exp);
    step();
    read_reg   = 1'b0;
    check("rd_consumed", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic pt(input logic [15:0] a, input logic [31:0] v);
    read_reg        = 1'b1;
    busaddress      = a;
    busdata_fromhm2 = v;
    step();
    read_reg        = 1'b0;
    check("passthrough", 256'(busdata_out), 256'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P-1:0] rsv;
    int bad;
    rsv = '0;
    for (int i = 0; i < P; i++) if ((i % 36) >= 34) rsv[i] = 1'b1;

    // Read strobe while in reset must not produce a response
    reset_reg_N = 1'b0; write_reg = 1'b0; read_reg = 1'b1; busaddress = 16'h1400;
    busdata_in = '0; busdata_fromhm2 = '0; pin_in = '0;
    step();
    check("rst_read_suppressed", 256'(read_valid), 256'(0));
    read_reg = 1'b0;
    step();
    check("rst_busdata", 256'(busdata_out), 256'(0));
    check("rst_irq", 256'(irq), 256'(0));
    check("rst_oe", 256'(oe), 256'(rsv));
    check("rst_od", 256'(od), 256'(0));
    bad = 0;
    for (int i = 0; i < P; i++) if (portsel[i*PNW +: PNW] !== 8'(i)) bad++;
    check("rst_portsel_identity", 256'(bad), 256'(0));

    // Strobe in first cycle after release is honoured
    reset_reg_N = 1'b1;
    rd(16'h1400, 32'h03020100);
    step();

    // DDR window
    wr(16'h1100, 32'h00FFFFFF);
    check("ddr_w0", 256'(oe[23:0]), 256'(24'hFFFFFF));
    wr(16'h1104, 32'hFFFFFFFF);
    check("ddr_w1", 256'(oe[47:24]), 256'(24'hFFFFFF));
    rd(16'h1104, 32'h00FFFFFF);
    wr(16'h1104, 32'h00000000);
    check("ddr_w1_rsv_kept", 256'(oe[47:24]), 256'(24'h000C00));
    rd(16'h1104, 32'h00000C00);
    rd(16'h1108, 32'h00C00000);
    rd(16'h1114, 32'h00C00000);
    wr(16'h1118, 32'hFFFFFFFF);
    pt(16'h1118, 32'h12345678);
    check("ddr_full", 256'(oe), 256'(rsv | 144'hFFFFFF));

    // MUX window
    wr(16'h1420, 32'h11223344);
    check("psel32", 256'(portsel[32*PNW +: PNW]), 256'(8'h44));
    check("psel33", 256'(portsel[33*PNW +: PNW]), 256'(8'h33));
    check("psel34", 256'(portsel[34*PNW +: PNW]), 256'(8'd34));
    check("psel35", 256'(portsel[35*PNW +: PNW]), 256'(8'd35));
    rd(16'h1420, 32'h23223344);
    rd(16'h1404, 32'h07060504);
    rd(16'h148C, 32'h8F8E8D8C);
    pt(16'h1490, 32'hCAFEF00D);

    // ODRAIN: simultaneous write and read returns the old value
    write_reg = 1'b1; read_reg = 1'b1; busaddress = 16'h1300; busdata_in = 32'h5;
    exp_q.push_back(32'h0);
    step();
    write_reg = 1'b0; read_reg = 1'b0;
    check("od_w0", 256'(od[23:0]), 256'(24'h000005));
    rd(16'h1300, 32'h5);
    wr(16'h1304, 32'hFFFFFFFF);
    check("od_rsv_kept", 256'(od[47:24]), 256'(24'hFFF3FF));
    rd(16'h1304, 32'h00FFF3FF);

    pt(16'h1700, 32'hDEADBEEF);

    // Edge detect latency and irq
    wr(16'h1500, 32'h1);
    pin_in[0] = 1'b1;
    step();
    read_reg = 1'b1; busaddress = 16'h1600; exp_q.push_back(32'h0);
    step();
    read_reg = 1'b0;
    check("irq_e1", 256'(irq), 256'(0));
    step();
    check("irq_e2", 256'(irq), 256'(0));
    rd(16'h1600, 32'h1);
    check("irq_e3", 256'(irq), 256'(1));

    // Clear with no edge
    wr(16'h1600, 32'h1);
    rd(16'h1600, 32'h0);
    check("irq_cleared", 256'(irq), 256'(0));

    // Clear coinciding with a new edge: edge wins
    pin_in[0] = 1'b0;
    step(); step(); step();
    pin_in[0] = 1'b1;
    step(); step();
    wr(16'h1600, 32'h1);
    rd(16'h1600, 32'h1);
    check("irq_edge_wins", 256'(irq), 256'(1));

    // Masking enable leaves status intact
    wr(16'h1500, 32'h0);
    rd(16'h1600, 32'h1);
    check("irq_masked", 256'(irq), 256'(0));
    rd(16'h1500, 32'h0);

    // INPUT window via synchroniser; writes ignored
    pin_in[47:24] = 24'hA5A5A5;
    step(); step();
    rd(16'h1200, 32'h1);
    wr(16'h1204, 32'hFFFFFFFF);
    rd(16'h1204, 32'h00A5A5A5);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
